// File: rtl/async_pkg.sv
// Shared constants and types for the dual-rail async link blocks.
package async_pkg;

    localparam int RAIL_NUM  = 2;
    localparam int RAIL_ZERO = 0;
    localparam int RAIL_ONE  = 1;

    typedef enum logic {
        ENC_TP,
        ENC_FP
    } enc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_SPACER
    } dr_tx_state_t;

endpackage

// File: rtl/ack_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, reset to 0.
module ack_sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    if (SYNC_STAGES < 2) begin : g_badStages
        $error("ack_sync_ff: SYNC_STAGES must be at least 2");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/dr_tx.sv
// Synchronous valid/ready to dual-rail (two-phase or four-phase) link transmitter.
// Optional ack-timeout flag enabled by defining DR_TX_ACK_TIMEOUT_EN.
module dr_tx
    import async_pkg::*;
#(
    parameter string ENC            = "TP",
    parameter int    WIDTH          = 1,
    parameter int    SYNC_STAGES    = 2,
    parameter int    TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic [WIDTH-1:0][RAIL_NUM-1:0]   out,
    input  logic                             ack_i,
    output logic                             busy,
    output logic                             err
);

    localparam enc_t ENC_SEL = (ENC == "FP") ? ENC_FP : ENC_TP;
    localparam bit   IS_FP   = (ENC_SEL == ENC_FP);

    if (ENC != "TP" && ENC != "FP") begin : g_badEnc
        $error("dr_tx: ENC must be \"TP\" or \"FP\"");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("dr_tx: TIMEOUT_CYCLES must be positive");
    end

    dr_tx_state_t                       r_state;
    logic [WIDTH-1:0][RAIL_NUM-1:0]     r_out;
    logic                               r_ready;
    logic                               r_busy;
    logic                               r_phase;
    logic                               w_ack_s;
    logic                               w_leave;

    ack_sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ackSync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(ack_i),
        .o_sync (w_ack_s)
    );

    // The receiver's answer for the current state has arrived.
    always_comb begin
        w_leave = 1'b0;
        case (r_state)
            ST_DATA:   w_leave = IS_FP ? w_ack_s : (w_ack_s != r_phase);
            ST_SPACER: w_leave = !w_ack_s;
            default:   w_leave = 1'b0;
        endcase
    end

    // The rail flops themselves hold the accepted word until the cycle completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_phase <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (in_valid && r_ready) begin
                        for (int b = 0; b < WIDTH; b++) begin
                            if (IS_FP) begin
                                r_out[b][RAIL_ONE]  <= in_data[b];
                                r_out[b][RAIL_ZERO] <= ~in_data[b];
                            end else if (in_data[b]) begin
                                r_out[b][RAIL_ONE]  <= ~r_out[b][RAIL_ONE];
                            end else begin
                                r_out[b][RAIL_ZERO] <= ~r_out[b][RAIL_ZERO];
                            end
                        end
                        r_state <= ST_DATA;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_leave) begin
                        if (IS_FP) begin
                            r_out   <= '0;
                            r_state <= ST_SPACER;
                        end else begin
                            r_phase <= ~r_phase;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_SPACER: begin
                    if (w_leave) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out      = r_out;
    assign in_ready = r_ready;
    assign busy     = r_busy;

`ifdef DR_TX_ACK_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_toCnt;
    logic             r_err;

    // Wait time in the current state; err is sticky and never aborts the token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toCnt <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ST_IDLE || w_leave) begin
            r_toCnt <= '0;
        end else if (r_toCnt != CNT_MAX) begin
            r_toCnt <= r_toCnt + 1'b1;
            if (r_toCnt == CNT_MAX - 1'b1) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/dr_tx.md
Name: dr_tx

Overview:
- Clocked-domain transmitter that encodes single-rail words onto a dual-rail delay-insensitive link.
- Sits directly upstream of the dual-rail receiver/synchronizer stage: drives its `in` rails and consumes its `ack_o`.
- Supports two-phase (TP, transition signalling) and four-phase (FP, return-to-zero) encoding.
- Upstream side is a synchronous valid/ready port.

Parameters:
- ENC, "TP", link encoding: "TP" two-phase or "FP" four-phase.
- WIDTH, 1, data bits per token.
- SYNC_STAGES, 2, flops in the ack synchronizer (minimum 2).
- TIMEOUT_CYCLES, 1024, ack-wait limit; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  upstream word.
- out  output  [WIDTH-1:0][1:0]  dual-rail link; `[b][1]` is the 1-rail and `[b][0]` is the 0-rail of bit b.
- ack_i  input  1  asynchronous acknowledge from the receiver.
- busy  output  1  token in flight on the link.
- err  output  1  sticky ack-timeout flag.

Behaviour:
- Reset (rst_n=0, async):
  - out=0 on all rails; in_ready=0 while rst_n=0, then 1 from the first clock edge after release.
  - busy=0; err=0; phase=0; ack synchronizer flops=0.
  - Link reset must be applied together with the receiver reset.
- Outputs:
  - Every rail is driven directly from a flop; no combinational path from in_data to out.
  - Each rail changes at most once per clock edge, so the link is glitch-free.
- Ack sampling: ack_i passes through SYNC_STAGES flops to give ack_s. Only ack_s is used by the FSM.
- Handshake:
  - in_ready=1 only in IDLE.
  - A word is accepted on an edge with in_valid&&in_ready.
  - The word is held in an internal register until the link cycle completes.
- FSM states: IDLE, DATA, SPACER (SPACER is FP only).
- FP sequence:
  - IDLE accept: at that edge out[b] <= {d_b, ~d_b}, one-hot per bit. Go to DATA; busy=1.
  - DATA: wait for ack_s==1, then out <= 0 (spacer) and go to SPACER.
  - SPACER: wait for ack_s==0, then go to IDLE; busy=0, in_ready=1.
- TP sequence:
  - IDLE accept: for each bit toggle rail d_b (toggle out[b][1] if d_b=1, else out[b][0]). Exactly one transition per bit per token. Go to DATA; busy=1.
  - DATA: wait for ack_s != phase, then phase <= ~phase and go to IDLE.
- Latency:
  - Rails change on the accept edge.
  - Minimum next accept, TP: SYNC_STAGES+1 cycles after ack_i toggles.
  - Minimum next accept, FP: SYNC_STAGES+1 cycles after ack_i falls.
- Boundary conditions:
  - in_valid while not in IDLE: ignored; in_ready=0, nothing is lost because in_ready gates acceptance.
  - ack_s changing in IDLE (spurious): ignored.
  - FP ack_s already 1 on entry to DATA: treated as protocol error; the FSM still waits for the sequence and err is not set. The bench flags it.
  - WIDTH=1: legal.
  - rst_n asserted mid-token: rails go to 0 immediately and the token is dropped.

Optional Feature:
- Macro: DR_TX_ACK_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in DATA and SPACER and clears on every state change.
  - When the counter reaches TIMEOUT_CYCLES, err <= 1 and stays set until reset.
  - The FSM keeps waiting; the token is not aborted.
- Without the macro: no counter; err is tied to 0.

Decomposition:
- Shared package async_pkg holds:
  - RAIL_NUM=2 and the rail index constants RAIL_ZERO=0, RAIL_ONE=1.
  - The encoding enum (ENC_TP, ENC_FP).
  - The dr_tx state typedef.
- Sub-module ack_sync_ff: SYNC_STAGES-deep async-reset synchronizer, 1 bit, reset value 0. It can be reused by other clocked stages of the async link.

Test Plan:
- FP, WIDTH=4:
  - Stimulus: accept 4'b1010; ack_i rises 3 cycles later, then falls.
  - Required response: out={10,01,10,01}; then out=0 exactly SYNC_STAGES+1 cycles after the ack rise; in_ready=1 SYNC_STAGES+1 cycles after the ack fall.
- TP, WIDTH=4:
  - Stimulus: send 4'b1100 then 4'b1100, with one ack toggle each.
  - Required response:
    - After token 1: out={10,10,01,01}.
    - After token 2: all rails are back to 0.
    - Exactly one rail toggles per bit per token; phase ends at 0.
- Back-pressure: hold in_valid=1 with data 0x5 during DATA -> no rail change and in_ready=0 until ack completes; 0x5 is accepted next.
- Reset mid-token, FP:
  - Stimulus: pull rst_n low while in DATA.
  - Required response: out=0 and busy=0 immediately (async); after release, in_ready=1 on the next edge.
- Spurious ack in IDLE: toggle ack_i with no token -> out unchanged, busy=0.
- With DR_TX_ACK_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Stimulus: send a token and never ack.
  - Required response: err=1 after 16 cycles in DATA and stays 1; a later ack still completes the token.
